// File: rtl/pid_core_mc.sv
// Decimated PID loop filter: error stage, P/I/D products with IIR-filtered D term,
// then a saturating integrator with conditional-integration anti-windup and an output clamp.
module pid_core_mc #(
  parameter int DW   = 16,
  parameter int SPW  = 14,
  parameter int GW   = 16,
  parameter int FRAC = 13,
  parameter int DECW = 14,
  parameter int ACCW = DW + GW + 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable_i,
  input  logic            strobe_i,
  input  logic [DW-1:0]   dat_i,
  input  logic [SPW-1:0]  sp_i,
  input  logic [GW-1:0]   kp_i,
  input  logic [GW-1:0]   ki_i,
  input  logic [GW-1:0]   kd_i,
  input  logic [3:0]      alpha_i,
  input  logic [DECW-1:0] decimate_i,
  input  logic [4:0]      satwidth_i,
  input  logic            int_clr_i,
  output logic [DW-1:0]   dat_o,
  output logic            valid_o,
  output logic            sat_o
);
  localparam int EW    = DW + 1;
  localparam int RW    = DW + 2;
  localparam int RW1   = RW + 1;
  localparam int PW    = GW + EW;
  localparam int DPW   = GW + RW;
  localparam int ACCW1 = ACCW + 1;
  localparam int SW    = ACCW + 3;

  logic [DECW-1:0]         cnt_q, cnt_d;
  logic                    tick;
  logic                    s1_v_q, s2_v_q, valid_q;
  logic signed [EW-1:0]    e_d, e1_q, e_prev_q;
  logic signed [RW-1:0]    rd_d, rd1_q;
  logic signed [RW1-1:0]   df_diff;
  logic signed [RW-1:0]    dfilt_d, dfilt_q;
  logic signed [PW-1:0]    p_d, p2_q, iinc_d, iinc2_q;
  logic signed [DPW-1:0]   d_d, d2_q;
  logic signed [ACCW1-1:0] isum;
  logic signed [ACCW-1:0]  isat, integ_d, integ_q;
  logic                    skip, iinc_pos, iinc_neg;
  logic signed [SW-1:0]    sum, shifted, lim_hi, lim_lo, clamped;
  logic [5:0]              sw;
  logic                    sat_d, sat_pos_d, sat_q, sat_pos_q;
  logic [DW-1:0]           dat_d, dat_q;

  // cnt >= decimate_i (not ==) so lowering decimate_i below cnt ticks on the next strobe
  always_comb begin
    tick  = enable_i && strobe_i && (cnt_q >= decimate_i);
    cnt_d = cnt_q;
    if (enable_i && strobe_i) cnt_d = tick ? '0 : cnt_q + DECW'(1);
  end

  always_comb begin
    e_d     = EW'($signed(sp_i)) - EW'($signed(dat_i));
    rd_d    = RW'(e_d) - RW'(e_prev_q);
    df_diff = RW1'(rd1_q) - RW1'(dfilt_q);
    dfilt_d = dfilt_q + RW'(df_diff >>> alpha_i);
    p_d     = PW'($signed(kp_i)) * PW'(e1_q);
    iinc_d  = PW'($signed(ki_i)) * PW'(e1_q);
    d_d     = DPW'($signed(kd_i)) * DPW'(dfilt_d);
  end

  // Integrator saturates on overflow of the extra top bit; freeze while pushing further into the clamp.
  always_comb begin
    isum     = ACCW1'(integ_q) + ACCW1'(iinc2_q);
    isat     = (isum[ACCW] != isum[ACCW-1]) ?
               (isum[ACCW] ? {1'b1, {(ACCW-1){1'b0}}} : {1'b0, {(ACCW-1){1'b1}}}) :
               isum[ACCW-1:0];
    iinc_neg = iinc2_q[PW-1];
    iinc_pos = !iinc2_q[PW-1] && (iinc2_q != '0);
    skip     = sat_q && (sat_pos_q ? iinc_pos : iinc_neg);
    integ_d  = skip ? integ_q : isat;
    sum      = SW'(p2_q) + SW'(integ_d) + SW'(d2_q);
    shifted  = sum >>> FRAC;
  end

  always_comb begin
    if (satwidth_i == '0 || int'(satwidth_i) > DW) sw = 6'(DW);
    else if (satwidth_i == 5'd1)                   sw = 6'd2;
    else                                           sw = {1'b0, satwidth_i};
    lim_hi    = (SW'(1) <<< (sw - 6'd1)) - SW'(1);
    lim_lo    = -lim_hi - SW'(1);
    clamped   = shifted;
    sat_d     = 1'b0;
    sat_pos_d = 1'b0;
    if (shifted > lim_hi) begin
      clamped   = lim_hi;
      sat_d     = 1'b1;
      sat_pos_d = 1'b1;
    end else if (shifted < lim_lo) begin
      clamped = lim_lo;
      sat_d   = 1'b1;
    end
    dat_d = DW'(clamped);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      s1_v_q    <= 1'b0;
      s2_v_q    <= 1'b0;
      valid_q   <= 1'b0;
      e1_q      <= '0;
      rd1_q     <= '0;
      e_prev_q  <= '0;
      dfilt_q   <= '0;
      p2_q      <= '0;
      iinc2_q   <= '0;
      d2_q      <= '0;
      integ_q   <= '0;
      dat_q     <= '0;
      sat_q     <= 1'b0;
      sat_pos_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      s1_v_q  <= tick;
      s2_v_q  <= s1_v_q;
      valid_q <= s2_v_q;
      if (tick) begin
        e1_q     <= e_d;
        rd1_q    <= rd_d;
        e_prev_q <= e_d;
      end
      if (s1_v_q) begin
        dfilt_q <= dfilt_d;
        p2_q    <= p_d;
        iinc2_q <= iinc_d;
        d2_q    <= d_d;
      end
      if (s2_v_q) begin
        integ_q   <= integ_d;
        dat_q     <= dat_d;
        sat_q     <= sat_d;
        sat_pos_q <= sat_pos_d;
      end
      if (int_clr_i) begin
        integ_q  <= '0;
        e_prev_q <= '0;
        dfilt_q  <= '0;
      end
    end
  end

  assign dat_o   = dat_q;
  assign valid_o = valid_q;
  assign sat_o   = sat_q;
endmodule

// File: tb/tb_pid_core_mc.sv
// Directed bench for pid_core_mc: latency, P/I/D paths, decimation, clamp, anti-windup, reset/clear.
module tb_pid_core_mc;
  logic        clk = 1'b0;
  logic        rst, enable_i, strobe_i, int_clr_i;
  logic [15:0] dat_i, kp_i, ki_i, kd_i;
  logic [13:0] sp_i, decimate_i;
  logic [3:0]  alpha_i;
  logic [4:0]  satwidth_i;
  logic [15:0] dat_o;
  logic        valid_o, sat_o;
  int          checks = 0;
  int          errors = 0;

  pid_core_mc #(.DW(16), .SPW(14), .GW(16), .FRAC(13), .DECW(14)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .strobe_i(strobe_i), .dat_i(dat_i),
    .sp_i(sp_i), .kp_i(kp_i), .ki_i(ki_i), .kd_i(kd_i), .alpha_i(alpha_i),
    .decimate_i(decimate_i), .satwidth_i(satwidth_i), .int_clr_i(int_clr_i),
    .dat_o(dat_o), .valid_o(valid_o), .sat_o(sat_o)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1; enable_i = 1'b1; strobe_i = 1'b0; int_clr_i = 1'b0;
    dat_i = '0; sp_i = '0; kp_i = '0; ki_i = '0; kd_i = '0;
    alpha_i = '0; decimate_i = '0; satwidth_i = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic strobe(input logic signed [15:0] d);
    @(posedge clk); #1;
    dat_i = d; strobe_i = 1'b1;
    @(posedge clk); #1;
    strobe_i = 1'b0;
  endtask

  task automatic wait_valid(output logic got);
    got = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (valid_o) begin got = 1'b1; break; end
    end
  endtask

  task automatic run_sample(input logic signed [15:0] d, output logic got);
    strobe(d);
    wait_valid(got);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (dat_o !== 16'd0) begin errors++; $display("FAIL reset_dat: got %0d want 0", dat_o); end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
    checks++; if (sat_o !== 1'b0) begin errors++; $display("FAIL reset_sat: got %b want 0", sat_o); end
  endtask

  task automatic test_p_only();
    do_reset();
    kp_i = 16'd8192;
    strobe(-16'sd100);
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL p_early_valid: got %b want 0", valid_o); end
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL p_valid: got %b want 1", valid_o); end
    checks++; if ($signed(dat_o) !== 100) begin errors++; $display("FAIL p_dat: got %0d want 100", $signed(dat_o)); end
    checks++; if (sat_o !== 1'b0) begin errors++; $display("FAIL p_sat: got %b want 0", sat_o); end
    @(posedge clk); #1;
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL p_pulse_width: got %b want 0", valid_o); end
  endtask

  task automatic test_i_ramp();
    logic got;
    do_reset();
    ki_i = 16'd8192;
    for (int k = 1; k <= 3; k++) begin
      run_sample(-16'sd10, got);
      checks++;
      if (!got || $signed(dat_o) !== 10 * k) begin
        errors++; $display("FAIL i_ramp[%0d]: got %0d valid=%b want %0d", k, $signed(dat_o), got, 10 * k);
      end
    end
    @(posedge clk); #1 int_clr_i = 1'b1;
    @(posedge clk); #1 int_clr_i = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      run_sample(-16'sd10, got);
      checks++;
      if (!got || $signed(dat_o) !== 10 * k) begin
        errors++; $display("FAIL int_clr_ramp[%0d]: got %0d valid=%b want %0d", k, $signed(dat_o), got, 10 * k);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    kp_i = 16'd8192;
    @(posedge clk); #1 strobe_i = 1'b1; dat_i = -16'sd1;
    @(posedge clk); #1 dat_i = -16'sd2;
    @(posedge clk); #1 dat_i = -16'sd3;
    @(posedge clk); #1 strobe_i = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (valid_o !== 1'b1 || $signed(dat_o) !== k) begin
        errors++; $display("FAIL b2b[%0d]: got %0d valid=%b want %0d", k, $signed(dat_o), valid_o, k);
      end
      @(posedge clk); #1;
    end
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_end_valid: got %b want 0", valid_o); end
  endtask

  task automatic test_decimation();
    logic got;
    int pulses = 0;
    do_reset();
    kp_i = 16'd8192; decimate_i = 14'd2;
    for (int i = 1; i <= 9; i++) begin
      run_sample(-16'sd7, got);
      if (got) pulses++;
      checks++;
      if (got !== (i % 3 == 0)) begin
        errors++; $display("FAIL decim_strobe[%0d]: got valid=%b want %b", i, got, (i % 3 == 0));
      end
    end
    checks++; if (pulses !== 3) begin errors++; $display("FAIL decim_count: got %0d want 3", pulses); end
    decimate_i = 14'd5;
    run_sample(-16'sd7, got);
    run_sample(-16'sd7, got);
    decimate_i = 14'd1;
    run_sample(-16'sd7, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL decim_lowered: got valid=%b want 1", got); end
  endtask

  task automatic test_clamp();
    logic got;
    logic signed [15:0] din   [6] = '{-16'sd200, -16'sd200, -16'sd200, -16'sd200, -16'sd200, 16'sd200};
    int                 exp_d [6] = '{200, 400, 511, 511, 511, 400};
    logic               exp_s [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic signed [15:0] din2  [6] = '{16'sd100, -16'sd100, -16'sd1, -16'sd32768, -16'sd32767, 16'sd32767};
    logic [4:0]         sw2   [6] = '{5'd1, 5'd1, 5'd1, 5'd0, 5'd0, 5'd20};
    int                 exp_d2[6] = '{-2, 1, 1, 32767, 32767, -32767};
    logic               exp_s2[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    do_reset();
    ki_i = 16'd8192; satwidth_i = 5'd10;
    for (int k = 0; k < 6; k++) begin
      run_sample(din[k], got);
      checks++;
      if (!got || $signed(dat_o) !== exp_d[k] || sat_o !== exp_s[k]) begin
        errors++; $display("FAIL windup[%0d]: got %0d sat=%b valid=%b want %0d sat=%b",
                           k, $signed(dat_o), sat_o, got, exp_d[k], exp_s[k]);
      end
    end
    do_reset();
    kp_i = 16'd8192;
    for (int k = 0; k < 6; k++) begin
      satwidth_i = sw2[k];
      run_sample(din2[k], got);
      checks++;
      if (!got || $signed(dat_o) !== exp_d2[k] || sat_o !== exp_s2[k]) begin
        errors++; $display("FAIL clamp_edge[%0d]: got %0d sat=%b valid=%b want %0d sat=%b",
                           k, $signed(dat_o), sat_o, got, exp_d2[k], exp_s2[k]);
      end
    end
  endtask

  task automatic test_dfilter();
    logic got;
    logic signed [15:0] din  [5] = '{16'sd0, -16'sd400, -16'sd400, -16'sd400, -16'sd400};
    int                 exp_d[5] = '{0, 100, 75, 56, 42};
    do_reset();
    kd_i = 16'd8192; alpha_i = 4'd2;
    for (int k = 0; k < 5; k++) begin
      run_sample(din[k], got);
      checks++;
      if (!got || $signed(dat_o) !== exp_d[k]) begin
        errors++; $display("FAIL dfilt[%0d]: got %0d valid=%b want %0d", k, $signed(dat_o), got, exp_d[k]);
      end
    end
  endtask

  task automatic test_enable();
    logic got;
    do_reset();
    kp_i = 16'd8192;
    run_sample(-16'sd5, got);
    checks++; if (!got || $signed(dat_o) !== 5) begin errors++; $display("FAIL en_first: got %0d want 5", $signed(dat_o)); end
    enable_i = 1'b0;
    run_sample(-16'sd9, got);
    checks++; if (got !== 1'b0) begin errors++; $display("FAIL en_ignored: got valid=%b want 0", got); end
    checks++; if ($signed(dat_o) !== 5) begin errors++; $display("FAIL en_hold: got %0d want 5", $signed(dat_o)); end
    enable_i = 1'b1;
    strobe(-16'sd9);
    enable_i = 1'b0;
    wait_valid(got);
    checks++; if (!got || $signed(dat_o) !== 9) begin errors++; $display("FAIL en_inflight: got %0d valid=%b want 9", $signed(dat_o), got); end
    enable_i = 1'b1; decimate_i = 14'd1;
    run_sample(-16'sd3, got);
    enable_i = 1'b0;
    run_sample(-16'sd3, got);
    run_sample(-16'sd3, got);
    enable_i = 1'b1;
    run_sample(-16'sd3, got);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL en_cnt_hold: got valid=%b want 1", got); end
  endtask

  task automatic test_reset_mid();
    logic got;
    do_reset();
    ki_i = 16'd8192;
    run_sample(-16'sd10, got);
    checks++; if (!got || $signed(dat_o) !== 10) begin errors++; $display("FAIL rmid_pre: got %0d want 10", $signed(dat_o)); end
    strobe(-16'sd10);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (dat_o !== 16'd0 || valid_o !== 1'b0 || sat_o !== 1'b0) begin
      errors++; $display("FAIL rmid_clear: got dat=%0d valid=%b sat=%b want 0/0/0", dat_o, valid_o, sat_o);
    end
    rst = 1'b0;
    wait_valid(got);
    checks++; if (got !== 1'b0) begin errors++; $display("FAIL rmid_discard: got valid=%b want 0", got); end
    run_sample(-16'sd10, got);
    checks++; if (!got || $signed(dat_o) !== 10) begin errors++; $display("FAIL rmid_restart: got %0d want 10", $signed(dat_o)); end
  endtask

  initial begin
    test_reset();
    test_p_only();
    test_i_ramp();
    test_back_to_back();
    test_decimation();
    test_clamp();
    test_dfilter();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
